// File: rtl/paddle_ctrl.sv
// Per-player paddle controller: button sync/debounce, accelerated per-frame movement
// with clamping, and the per-frame enable that starts the paddle renderer on its top row.
module paddle_ctrl #(
  parameter int p_V_VISIBLE    = 480,
  parameter int p_PADDLE_HEIGHT = 50,
  parameter int p_INIT_Y       = 215,
  parameter int p_DEBOUNCE     = 250000,
  parameter int p_SLOW_STEP    = 1,
  parameter int p_FAST_STEP    = 4,
  parameter int p_ACCEL_FRAMES = 8
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_VBlank,
  input  logic       i_BtnUp,
  input  logic       i_BtnDown,
  output logic       o_Enabled,
  output logic [9:0] o_PosY
);

  localparam int DBW = $clog2(p_DEBOUNCE + 1);
  localparam int FCW = $clog2(p_ACCEL_FRAMES + 1);
  localparam logic [10:0] MAX_Y    = 11'(p_V_VISIBLE - p_PADDLE_HEIGHT);
  localparam logic [10:0] SLOW_STEP = 11'(p_SLOW_STEP);
  localparam logic [10:0] FAST_STEP = 11'(p_FAST_STEP);
  localparam logic [9:0]  ROW_MAX  = 10'(p_V_VISIBLE);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]     meta_q, sync_q, deb_q;
  logic [DBW-1:0] dbCnt_q [2];

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      dbCnt_q[0] <= '0;
      dbCnt_q[1] <= '0;
    end else begin
      meta_q <= {i_BtnDown, i_BtnUp};
      sync_q <= meta_q;
      for (int b = 0; b < 2; b++) begin
        if (sync_q[b] == deb_q[b]) begin
          dbCnt_q[b] <= '0;
        end else if (dbCnt_q[b] == DBW'(p_DEBOUNCE - 1)) begin
          deb_q[b]   <= sync_q[b];
          dbCnt_q[b] <= '0;
        end else begin
          dbCnt_q[b] <= dbCnt_q[b] + 1'b1;
        end
      end
    end
  end

  dir_t dir;

  always_comb begin
    dir = DIR_NONE;
    if (deb_q[0] && !deb_q[1]) begin
      dir = DIR_UP;
    end else if (deb_q[1] && !deb_q[0]) begin
      dir = DIR_DOWN;
    end
  end

  state_t         state_q, state_d;
  dir_t           latchDir_q, latchDir_d;
  logic [FCW-1:0] frameCnt_q, frameCnt_d;
  logic [9:0]     posY_q, posY_d;
  logic [10:0]    step;
  logic [10:0]    posWide;
  logic [10:0]    posSum;

  always_comb begin
    state_d    = state_q;
    latchDir_d = latchDir_q;
    frameCnt_d = frameCnt_q;
    posY_d     = posY_q;
    step       = '0;
    posWide    = {1'b0, posY_q};
    posSum     = '0;

    if (i_VReset) begin
      unique case (state_q)
        IDLE: begin
          if (dir != DIR_NONE) begin
            state_d    = SLOW;
            step       = SLOW_STEP;
            frameCnt_d = FCW'(1);
            latchDir_d = dir;
          end
        end
        SLOW: begin
          if (dir == DIR_NONE) begin
            state_d = IDLE;
          end else if (dir != latchDir_q) begin
            step       = SLOW_STEP;
            frameCnt_d = FCW'(1);
            latchDir_d = dir;
          end else begin
            step       = SLOW_STEP;
            frameCnt_d = frameCnt_q + FCW'(1);
            if (frameCnt_q == FCW'(p_ACCEL_FRAMES - 1)) begin
              state_d = FAST;
            end
          end
        end
        FAST: begin
          if (dir == DIR_NONE) begin
            state_d = IDLE;
          end else if (dir != latchDir_q) begin
            state_d    = SLOW;
            step       = SLOW_STEP;
            frameCnt_d = FCW'(1);
            latchDir_d = dir;
          end else begin
            step = FAST_STEP;
          end
        end
        default: state_d = IDLE;
      endcase

      // The FSM keeps advancing at the limits; only the position saturates.
      if (dir == DIR_UP) begin
        posSum = (posWide < step) ? 11'd0 : posWide - step;
        posY_d = posSum[9:0];
      end else if (dir == DIR_DOWN) begin
        posSum = posWide + step;
        if (posSum > MAX_Y) begin
          posSum = MAX_Y;
        end
        posY_d = posSum[9:0];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      latchDir_q <= DIR_NONE;
      frameCnt_q <= '0;
      posY_q     <= 10'(p_INIT_Y);
    end else begin
      state_q    <= state_d;
      latchDir_q <= latchDir_d;
      frameCnt_q <= frameCnt_d;
      posY_q     <= posY_d;
    end
  end

  // Row counter and enable clear on the same VReset that updates the position,
  // so a move is honoured by the very frame that follows it.
  logic [9:0] row_q;
  logic       enabled_q;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      row_q     <= '0;
      enabled_q <= 1'b0;
    end else if (i_VReset) begin
      row_q     <= '0;
      enabled_q <= 1'b0;
    end else if (i_HReset && !i_VBlank) begin
      if (row_q != ROW_MAX) begin
        row_q <= row_q + 10'd1;
      end
      if (row_q == posY_q) begin
        enabled_q <= 1'b1;
      end
    end
  end

  assign o_Enabled = enabled_q;
  assign o_PosY    = posY_q;

endmodule
